// File: rtl/adiv5_pkg.sv
// rtl/adiv5_pkg.sv - shared ADIv5 command/response types, register maps and responder constants
//
// Purpose : types and constants shared by the ADIv5 initiators and the
//           target-side DP/MEM-AP responder.
// Ports   : none (package).
// Config  : none here; ADIV5_SUBWORD_EN is consumed by adiv5_dp_responder.
package adiv5_pkg;

  typedef enum logic [2:0] {
    STAT_FAULT   = 3'b001,
    STAT_TIMEOUT = 3'b010,
    STAT_OK      = 3'b100
  } adiv5_stat_e;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  addr;
    logic        apndp;
    logic        rnw;
  } adiv5_cmd_t;

  typedef struct packed {
    logic [31:0] data;
    adiv5_stat_e stat;
  } adiv5_resp_t;

  typedef enum logic [1:0] {
    DP_ABORT_IDR = 2'd0,
    DP_CTRL_STAT = 2'd1,
    DP_SELECT    = 2'd2,
    DP_RDBUFF    = 2'd3
  } adiv5_dp_addr_e;

  // AP register word index = {SELECT.apbank, cmd addr}
  typedef enum logic [5:0] {
    APREG_CSW  = 6'h00,
    APREG_TAR  = 6'h01,
    APREG_DRW  = 6'h03,
    APREG_BD0  = 6'h04,
    APREG_BD1  = 6'h05,
    APREG_BD2  = 6'h06,
    APREG_BD3  = 6'h07,
    APREG_CFG  = 6'h3D,
    APREG_BASE = 6'h3E,
    APREG_IDR  = 6'h3F
  } adiv5_ap_addr_e;

  typedef struct packed {
    logic        dbg_enabled;
    logic [22:0] rsvd_30_8;
    logic        tip;
    logic        rsvd_6;
    logic [1:0]  autoinc;
    logic        rsvd_3;
    logic [2:0]  width;
  } adiv5_csw_t;

  typedef struct packed {
    logic [7:0]  apsel;
    logic [15:0] rsvd_23_8;
    logic [3:0]  apbank;
    logic [3:0]  dpbank;
  } adiv5_select_t;

  localparam logic [2:0] CSW_BYTE = 3'b000;
  localparam logic [2:0] CSW_HALF = 3'b001;
  localparam logic [2:0] CSW_WORD = 3'b010;

  localparam logic [1:0] INC_NONE   = 2'b00;
  localparam logic [1:0] INC_SINGLE = 2'b01;
  localparam logic [1:0] INC_PACKED = 2'b10;

  localparam int CS_CSYSPWRUPACK = 31;
  localparam int CS_CSYSPWRUPREQ = 30;
  localparam int CS_CDBGPWRUPACK = 29;
  localparam int CS_CDBGPWRUPREQ = 28;
  localparam int CS_STICKYERR    = 5;
  localparam int ABORT_STKERRCLR = 2;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_BUS  = 2'd1,
    RSP_RESP = 2'd2
  } adiv5_rsp_state_e;

  localparam logic [31:0] DEFAULT_DPIDR   = 32'h2BA0_1477;
  localparam logic [31:0] DEFAULT_AP_IDR  = 32'h2477_0011;
  localparam logic [31:0] DEFAULT_AP_BASE = 32'hE00F_F003;

  // Byte lanes touched by an access of the given CSW width at addr_lo.
  function automatic logic [3:0] lane_enables(input logic [2:0] width, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (width)
      CSW_BYTE: be = 4'b0001 << addr_lo;
      CSW_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  // TAR increment for one DRW transfer; packed mode steps like single.
  function automatic logic [9:0] inc_step(input logic [2:0] width);
    logic [9:0] step;
    case (width)
      CSW_BYTE: step = 10'd1;
      CSW_HALF: step = 10'd2;
      default:  step = 10'd4;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/adiv5_memap_bus.sv
// rtl/adiv5_memap_bus.sv - MEM-AP bus master: req/ack handshake, timeout and byte enables
//
// Purpose : runs one memory access per start pulse, holds mem_req until
//           mem_ack or TIMEOUT request cycles, reports OK/FAULT/TIMEOUT.
// Ports   : clk, rst (async, active high)
//           start, start_we, start_addr, start_width, start_wdata - launch
//           mem_req/mem_we/mem_addr/mem_be/mem_wdata -> bus, mem_ack/mem_err/mem_rdata <- bus
//           done (one cycle, combinational), done_stat, done_rdata
module adiv5_memap_bus
  import adiv5_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        start_we,
  input  logic [31:0] start_addr,
  input  logic [2:0]  start_width,
  input  logic [31:0] start_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output adiv5_stat_e done_stat,
  output logic [31:0] done_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  // Number of completed request cycles without an ack; the edge that would
  // complete the TIMEOUT-th cycle ends the access.
  logic [CW-1:0] wait_cnt;
  logic          timed_out;

  assign timed_out  = (wait_cnt == CW'(TIMEOUT - 1));
  assign done       = mem_req && (mem_ack || timed_out);
  assign done_rdata = mem_rdata;

  always_comb begin
    done_stat = STAT_OK;
    if (mem_ack) begin
      if (mem_err) done_stat = STAT_FAULT;
    end else if (timed_out) begin
      done_stat = STAT_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      wait_cnt  <= '0;
    end else if (start) begin
      mem_req   <= 1'b1;
      mem_we    <= start_we;
      mem_addr  <= start_addr;
      mem_be    <= lane_enables(start_width, start_addr[1:0]);
      mem_wdata <= start_wdata;
      wait_cnt  <= '0;
    end else if (mem_req) begin
      if (done) mem_req  <= 1'b0;
      else      wait_cnt <= wait_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/adiv5_dp_responder.sv
// rtl/adiv5_dp_responder.sv - target-side ADIv5 DP plus single MEM-AP responder
//
// Purpose : consumes 36-bit {data,addr,APnDP,RnW} commands, returns 35-bit
//           {data,stat} responses; DRW/BDn accesses run on the memory bus.
// Ports   : clk, rst (async, active high)
//           cmd_valid/cmd_ready/cmd_data[35:0]     - command stream
//           resp_valid/resp_ready/resp_data[34:0]  - response stream
//           mem_req/mem_we/mem_addr/mem_be/mem_wdata, mem_ack/mem_err/mem_rdata - bus
// Config  : ADIV5_SUBWORD_EN enables byte/half CSW widths; otherwise width is fixed WORD.
module adiv5_dp_responder
  import adiv5_pkg::*;
#(
  parameter logic [31:0] DPIDR   = DEFAULT_DPIDR,
  parameter logic [31:0] AP_IDR  = DEFAULT_AP_IDR,
  parameter logic [31:0] AP_BASE = DEFAULT_AP_BASE,
  parameter int          TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [35:0] cmd_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [34:0] resp_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_rdata
);

  adiv5_rsp_state_e state, state_next;
  adiv5_cmd_t       cmd;
  adiv5_select_t    select_q;
  adiv5_csw_t       csw_rd;

  logic        cmd_ready_q;
  logic        sys_pwrup_req, dbg_pwrup_req, sticky_err;
  logic [31:0] rdbuff, tar;
  logic [1:0]  csw_autoinc;
  logic [2:0]  csw_width;
  logic        bus_is_drw, bus_is_read;
  logic [34:0] resp_q;

  logic        accept, bus_start;
  logic [5:0]  ap_reg;
  logic        ap_direct, ap_is_bd, ap_mem_access;
  logic [31:0] bus_addr, ctrl_stat, ap_read_value;
  logic [31:0] imm_data;
  adiv5_stat_e imm_stat;

  logic        bus_done;
  adiv5_stat_e bus_stat;
  logic [31:0] bus_rdata;

  assign cmd        = adiv5_cmd_t'(cmd_data);
  assign cmd_ready  = cmd_ready_q;
  assign resp_valid = (state == RSP_RESP);
  assign resp_data  = resp_q;

  assign accept    = (state == RSP_IDLE) && cmd_ready_q && cmd_valid;
  assign ap_reg    = {select_q.apbank, cmd.addr};
  // AP access that actually reaches the MEM-AP (no sticky error, AP 0 selected)
  assign ap_direct = cmd.apndp && !sticky_err && (select_q.apsel == 8'h00);
  assign ap_is_bd  = (ap_reg[5:2] == 4'b0001);
  assign ap_mem_access = ap_direct && ((ap_reg == APREG_DRW) || ap_is_bd);
  assign bus_addr  = ap_is_bd ? {tar[31:4], ap_reg[1:0], 2'b00} : tar;

  always_comb begin
    ctrl_stat                  = '0;
    ctrl_stat[CS_CSYSPWRUPACK] = sys_pwrup_req;
    ctrl_stat[CS_CSYSPWRUPREQ] = sys_pwrup_req;
    ctrl_stat[CS_CDBGPWRUPACK] = dbg_pwrup_req;
    ctrl_stat[CS_CDBGPWRUPREQ] = dbg_pwrup_req;
    ctrl_stat[CS_STICKYERR]    = sticky_err;
  end

  always_comb begin
    csw_rd             = '0;
    csw_rd.dbg_enabled = 1'b1;
    csw_rd.tip         = (state == RSP_BUS);
    csw_rd.autoinc     = csw_autoinc;
    csw_rd.width       = csw_width;
  end

  always_comb begin
    ap_read_value = '0;
    case (ap_reg)
      APREG_CSW:  ap_read_value = csw_rd;
      APREG_TAR:  ap_read_value = tar;
      APREG_BASE: ap_read_value = AP_BASE;
      APREG_IDR:  ap_read_value = AP_IDR;
      default:    ap_read_value = '0;
    endcase
  end

  // Response for commands that complete without bus activity.
  always_comb begin
    imm_data = '0;
    imm_stat = STAT_OK;
    if (!cmd.apndp) begin
      if (cmd.rnw) begin
        case (cmd.addr)
          DP_ABORT_IDR: imm_data = DPIDR;
          DP_CTRL_STAT: imm_data = ctrl_stat;
          DP_SELECT:    imm_data = select_q;
          default:      imm_data = rdbuff;
        endcase
      end
    end else if (sticky_err) begin
      imm_stat = STAT_FAULT;
    end else if (ap_direct && cmd.rnw) begin
      imm_data = rdbuff;  // posted read: hand back the previous result
    end
  end

  always_comb begin
    state_next = state;
    bus_start  = 1'b0;
    case (state)
      RSP_IDLE: begin
        if (accept) begin
          if (ap_mem_access) begin
            state_next = RSP_BUS;
            bus_start  = 1'b1;
          end else begin
            state_next = RSP_RESP;
          end
        end
      end
      RSP_BUS:  if (bus_done) state_next = RSP_RESP;
      RSP_RESP: if (resp_ready) state_next = RSP_IDLE;
      default:  state_next = RSP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RSP_IDLE;
      cmd_ready_q <= 1'b0;
    end else begin
      state       <= state_next;
      cmd_ready_q <= (state_next == RSP_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q        <= '0;
      sys_pwrup_req <= 1'b0;
      dbg_pwrup_req <= 1'b0;
      sticky_err    <= 1'b0;
      select_q      <= '0;
      rdbuff        <= '0;
      tar           <= '0;
      csw_autoinc   <= INC_NONE;
      bus_is_drw    <= 1'b0;
      bus_is_read   <= 1'b0;
    end else if (accept) begin
      resp_q      <= {imm_data, imm_stat};
      bus_is_drw  <= (ap_reg == APREG_DRW);
      bus_is_read <= cmd.rnw;
      if (!cmd.apndp) begin
        if (!cmd.rnw) begin
          case (cmd.addr)
            DP_ABORT_IDR: if (cmd.data[ABORT_STKERRCLR]) sticky_err <= 1'b0;
            DP_CTRL_STAT: begin
              sys_pwrup_req <= cmd.data[CS_CSYSPWRUPREQ];
              dbg_pwrup_req <= cmd.data[CS_CDBGPWRUPREQ];
            end
            DP_SELECT: select_q <= {cmd.data[31:24], 16'h0000, cmd.data[7:0]};
            default: ;
          endcase
        end
      end else if (ap_direct && !ap_mem_access) begin
        if (cmd.rnw) begin
          rdbuff <= ap_read_value;
        end else begin
          case (ap_reg)
            APREG_CSW: csw_autoinc <= cmd.data[5:4];
            APREG_TAR: tar         <= cmd.data;
            default: ;
          endcase
        end
      end
    end else if ((state == RSP_BUS) && bus_done) begin
      resp_q <= {(bus_is_read && (bus_stat == STAT_OK)) ? rdbuff : 32'h0, bus_stat};
      if (bus_stat == STAT_FAULT) sticky_err <= 1'b1;
      if (bus_stat == STAT_OK) begin
        if (bus_is_read) rdbuff <= bus_rdata;
        // TAR[31:10] is frozen, so incrementing wraps within the 1 KB page.
        if (bus_is_drw && ((csw_autoinc == INC_SINGLE) || (csw_autoinc == INC_PACKED)))
          tar <= {tar[31:10], tar[9:0] + inc_step(csw_width)};
      end
    end
  end

`ifdef ADIV5_SUBWORD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csw_width <= CSW_WORD;
    end else if (accept && ap_direct && !cmd.rnw && (ap_reg == APREG_CSW)) begin
      csw_width <= cmd.data[2:0];
    end
  end
`else
  assign csw_width = CSW_WORD;
`endif

  adiv5_memap_bus #(
    .TIMEOUT (TIMEOUT)
  ) u_bus (
    .clk         (clk),
    .rst         (rst),
    .start       (bus_start),
    .start_we    (!cmd.rnw),
    .start_addr  (bus_addr),
    .start_width (csw_width),
    .start_wdata (cmd.data),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_err     (mem_err),
    .mem_rdata   (mem_rdata),
    .done        (bus_done),
    .done_stat   (bus_stat),
    .done_rdata  (bus_rdata)
  );

endmodule

// File: doc/adiv5_dp_responder.md
# adiv5_dp_responder

Target-side ADIv5 debug port and single MEM-AP model. It consumes 36-bit ADIv5 command words (data/addr/APnDP/RnW) from a host FIFO and returns 35-bit response words (data/stat). AP accesses are executed on a simple word-addressed memory bus master. It is the responder at the other end of our ADIv5 initiators: a loopback target for benches, and an on-chip debug slave.

## Interface
- DPIDR, 32'h2BA0_1477, value returned for DP reads of address 0
- AP_IDR, 32'h2477_0011, AP IDR (0xFC) read value
- AP_BASE, 32'hE00F_F003, AP BASE (0xF8) read value
- TIMEOUT, 255, maximum mem_req cycles without mem_ack before the access is aborted
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command word present
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_data  in  36  {data[31:0], addr[1:0], APnDP, RnW}
- resp_valid  out  1  response word present
- resp_ready  in  1  response consumed when valid&&ready
- resp_data  out  35  {data[31:0], stat[2:0]}; stat is FAULT=001, TIMEOUT=010, OK=100
- mem_req  out  1  bus request, held until mem_ack or timeout
- mem_we  out  1  1 = write
- mem_addr  out  32  byte address (= TAR)
- mem_be  out  4  byte enables
- mem_wdata  out  32  write data, byte-lane aligned
- mem_ack  in  1  access complete, single cycle
- mem_err  in  1  bus error, qualified by mem_ack
- mem_rdata  in  32  read data, valid with mem_ack

## Operation
- FSM states: IDLE, BUS, RESP.
  - IDLE: cmd_ready=1. Register access goes to RESP. DRW/BDn access goes to BUS, unless the sticky error is set.
  - BUS: mem_req=1; ends on mem_ack or timeout, then goes to RESP.
  - RESP: resp_valid=1 until resp_ready, then IDLE.
- DP read:
  - addr 0 returns DPIDR.
  - addr 1 returns CTRL/STAT: bit31=bit30 (CSYSPWRUPACK mirrors its REQ), bit29=bit28, bit5 STICKYERR.
  - addr 2 returns SELECT.
  - addr 3 returns RDBUFF.
- DP write:
  - addr 0 is ABORT: bit2 clears STICKYERR, other bits are ignored.
  - addr 1 stores bits 30 and 28.
  - addr 2 stores SELECT (apsel[31:24], apbank[7:4], dpbank[3:0]).
  - addr 3 is ignored.
  - DP writes always return OK, data 0.
- AP register address = {SELECT.apbank, cmd addr}. If apsel≠0: reads return 0/OK, writes are ignored.
- AP registers:
  - CSW: width[2:0], autoinc[5:4], tip[7] (RO, 1 in BUS), dbg_enabled[31] (RO 1).
  - TAR.
  - DRW.
  - BD0–BD3: address {TAR[31:4], n, 2'b00}, no autoinc.
  - CFG reads 0; BASE and IDR come from the parameters.
  - Unmapped addresses read 0, and writes are ignored.
- AP reads are posted: the response data is the previous RDBUFF, and RDBUFF is updated with the new result. DP RDBUFF read returns RDBUFF without side effects.
- STICKYERR set: every AP access returns FAULT, with no bus activity and no register change. DP accesses are unaffected.
- Bus completion:
  - mem_err: FAULT, STICKYERR set, TAR unchanged.
  - Timeout: TIMEOUT status, mem_req dropped, STICKYERR unchanged, TAR unchanged.
  - Otherwise OK.
- Autoincrement (autoinc 01 or 10, packed treated as single): after an OK DRW access, TAR[9:0] += 1, 2 or 4 per width. TAR[31:10] never changes, so the address wraps at the 1 KB boundary.
- Byte lanes:
  - byte: mem_be = 1<<TAR[1:0].
  - half: mem_be = 4'b0011<<{TAR[1],1'b0}.
  - word: mem_be = 4'hF.
  - Write data is taken from cmd data unshifted (host places the lanes). Read data is returned unshifted.

## Timing
- Reset values:
  - cmd_ready=0 during RESET, 1 at the first clock after release.
  - resp_valid=0, resp_data=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
  - CTRL/STAT=0, SELECT=0, RDBUFF=0, TAR=0.
  - CSW width=WORD, autoinc=NONE.
- Register access: command accepted at edge N, resp_valid high from N+1.
- Bus access: mem_req high from N+1. mem_ack at edge M gives resp_valid from M+1, and mem_req low from M+1.
- Timeout: mem_req high for exactly TIMEOUT cycles, then TIMEOUT status.
- Only one command is in flight; cmd_ready=0 in BUS and RESP.
- resp_data is stable while resp_valid && !resp_ready.
- RESET asserted mid-operation: immediate return to IDLE with all reset values. mem_req drops asynchronously, and any pending response is lost.

## Configuration
- ADIV5_SUBWORD_EN defined: byte and half widths supported as above.
- Without it: CSW.width writes are ignored and read as WORD. mem_be=4'hF always, and autoinc steps by 4.

## Structure
- adiv5_pkg gains:
  - CTRL/STAT and ABORT bit-position constants.
  - A responder state enum.
  - Default DPIDR/AP_IDR constants.
- Reuse the existing command/response structs, stat enum, DP/AP address enums and CSW/SELECT structs.
- Sub-module adiv5_memap_bus: mem_req/ack handshake, timeout counter and byte-enable generation. It returns OK, FAULT or TIMEOUT plus rdata.

## Test plan
- DP read addr 0 after reset → data 32'h2BA0_1477, OK, resp_valid one cycle after accept.
- DP write CTRL/STAT 32'h5000_0000, then read → 32'hF000_0000, OK.
- CSW autoinc single+word, TAR=0x2000_03FC, two DRW writes acked → mem_addr 0x2000_03FC then 0x2000_0000 (1 KB wrap).
- AP read DRW twice (mem_rdata 0x11, 0x22), then DP RDBUFF → responses 0 (previous RDBUFF), 0x11, 0x22.
- DRW write with mem_err → FAULT, then AP read CSW → FAULT and no mem_req; ABORT 0x4, then CSW read → OK.
- DRW read with mem_ack withheld → mem_req high 255 cycles, TIMEOUT status, STICKYERR still 0.
